// File: rtl/taus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : taus_pkg
// Description : Constants shared by the Tausworthe link scrambler and
//               descrambler: per-component shift/mask parameters, default
//               seeds, the receive FSM state encoding and the header seeding
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package taus_pkg;

    // Component 1
    localparam int unsigned c_C1_L1   = 13;
    localparam int unsigned c_C1_L2   = 12;
    localparam int unsigned c_C1_R    = 19;
    localparam logic [31:0] c_C1_MASK = 32'hFFFF_FFFE;
    localparam logic [31:0] c_C1_SEED = 32'hFFFF_FFFF;

    // Component 2
    localparam int unsigned c_C2_L1   = 2;
    localparam int unsigned c_C2_L2   = 4;
    localparam int unsigned c_C2_R    = 25;
    localparam logic [31:0] c_C2_MASK = 32'hFFFF_FFF8;
    localparam logic [31:0] c_C2_SEED = 32'hCCCC_CCCC;

    // Component 3
    localparam int unsigned c_C3_L1   = 3;
    localparam int unsigned c_C3_L2   = 17;
    localparam int unsigned c_C3_R    = 11;
    localparam logic [31:0] c_C3_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] c_C3_SEED = 32'h00FF_00FF;

    typedef enum logic [0:0] {
        SYNC    = 1'b0,
        PAYLOAD = 1'b1
    } taus_state_e;

    // A seed whose masked bits are all zero would lock the component at zero,
    // so such a seed is replaced by the component default.
    function automatic logic [31:0] taus_seed(input logic [31:0] dflt,
                                              input logic [31:0] mask,
                                              input logic [31:0] hdr);
        logic [31:0] s;
        s = dflt ^ hdr;
        return ((s & mask) == 32'h0) ? dflt : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/taus_component_next.sv
`default_nettype none
// ============================================================================
// Module      : taus_component_next
// Description : Combinational single-step update of one Tausworthe component:
//                 b  = ((s << L1) ^ s) >> R
//                 s' = ((s & C) << L2) ^ b
// Ports       : i_state - current component state (32 bit)
//               o_state - next component state (32 bit)
// Revision    : 1.0 - initial release
// ============================================================================
module taus_component_next #(
    parameter int unsigned L1 = 13,
    parameter int unsigned L2 = 12,
    parameter int unsigned R  = 19,
    parameter logic [31:0] C  = 32'hFFFF_FFFE
) (
    input  logic [31:0] i_state,
    output logic [31:0] o_state
);

    logic [31:0] w_mix;
    logic [31:0] w_b;

    assign w_mix   = (i_state << L1) ^ i_state;
    assign w_b     = w_mix >> R;
    assign o_state = ((i_state & C) << L2) ^ w_b;

endmodule
`default_nettype wire

// File: rtl/taus_descrambler.sv
`default_nettype none
// ============================================================================
// Module      : taus_descrambler
// Description : Receive-side descrambler for the 32-bit Tausworthe link.
//               Each frame header reseeds a three-component combined
//               Tausworthe generator; each payload word is XORed with the
//               next keystream word. One-entry output register with
//               valid/ready handshake, 1-cycle latency, 1 word/cycle.
// Ports       : clk, rst                   - clock, synchronous active-high reset
//               in_valid/in_ready/in_data/in_sof   - framed scrambled input
//               out_valid/out_ready/out_data/out_last - plaintext output
//               frame_err                  - 1-cycle protocol error pulse
//               frame_cnt, err_cnt         - saturating statistics
// Config      : TAUS_DESCR_STATS_EN - when defined, frame_cnt/err_cnt are
//               implemented; otherwise they are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module taus_descrambler
    import taus_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              frame_err,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] err_cnt
);

    localparam logic [15:0] c_LAST = 16'(FRAME_LEN - 1);

    taus_state_e r_state;
    taus_state_e w_state_nxt;

    logic [31:0] r_s1, r_s2, r_s3;
    logic [31:0] w_n1, w_n2, w_n3;
    logic [15:0] r_cnt;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_last;
    logic        r_frame_err;

    logic        w_accept;
    logic        w_load_seed;
    logic        w_advance;
    logic        w_err;
    logic        w_frame_done;

    // Ready only depends on the output register; it stays high in SYNC so
    // headers and junk words are always consumed.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    taus_component_next #(.L1(c_C1_L1), .L2(c_C1_L2), .R(c_C1_R), .C(c_C1_MASK))
        u_c1 (.i_state(r_s1), .o_state(w_n1));
    taus_component_next #(.L1(c_C2_L1), .L2(c_C2_L2), .R(c_C2_R), .C(c_C2_MASK))
        u_c2 (.i_state(r_s2), .o_state(w_n2));
    taus_component_next #(.L1(c_C3_L1), .L2(c_C3_L2), .R(c_C3_R), .C(c_C3_MASK))
        u_c3 (.i_state(r_s3), .o_state(w_n3));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SYNC: begin
                if (w_accept && in_sof) begin
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // An early header keeps us in PAYLOAD with a fresh seed.
                if (w_accept && !in_sof && (r_cnt == c_LAST)) begin
                    w_state_nxt = SYNC;
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: decoded actions
    // ------------------------------------------------------------------
    always_comb begin
        w_load_seed  = 1'b0;
        w_advance    = 1'b0;
        w_err        = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            SYNC: begin
                w_load_seed = w_accept && in_sof;
                w_err       = w_accept && !in_sof;
            end
            PAYLOAD: begin
                w_load_seed  = w_accept && in_sof;
                w_err        = w_accept && in_sof;
                w_advance    = w_accept && !in_sof;
                w_frame_done = w_accept && !in_sof && (r_cnt == c_LAST);
            end
            default: begin
                w_load_seed = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Generator state, payload counter and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= c_C1_SEED;
            r_s2        <= c_C2_SEED;
            r_s3        <= c_C3_SEED;
            r_cnt       <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_last  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;

            if (w_load_seed) begin
                r_s1  <= taus_seed(c_C1_SEED, c_C1_MASK, in_data);
                r_s2  <= taus_seed(c_C2_SEED, c_C2_MASK, in_data);
                r_s3  <= taus_seed(c_C3_SEED, c_C3_MASK, in_data);
                r_cnt <= 16'd0;
            end else if (w_advance) begin
                r_s1  <= w_n1;
                r_s2  <= w_n2;
                r_s3  <= w_n3;
                r_cnt <= w_frame_done ? 16'd0 : r_cnt + 16'd1;
            end

            // A header accept may coincide with the pending word draining;
            // only a payload accept refills the register.
            if (w_advance) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data ^ w_n1 ^ w_n2 ^ w_n3;
                r_out_last  <= w_frame_done;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef TAUS_DESCR_STATS_EN
    logic [STAT_W-1:0] r_frame_cnt;
    logic [STAT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_frame_done && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_taus_descrambler.sv
`default_nettype none
// ============================================================================
// Module      : tb_taus_descrambler
// Description : Self-checking bench for taus_descrambler. A reference model
//               of the generator and framing FSM pushes expected output words
//               into a queue on every modelled accept; the DUT output is
//               compared against the queue head each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taus_descrambler;

    localparam int unsigned FL = 16;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'h0;
    logic          in_sof = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic          out_last;
    logic          frame_err;
    logic [SW-1:0] frame_cnt;
    logic [SW-1:0] err_cnt;

    taus_descrambler #(.FRAME_LEN(FL), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          rnd_ready = 1'b0;

    // Reference model state
    logic [31:0] m_s1, m_s2, m_s3;
    bit          m_payload;
    int          m_cnt;
    bit          m_ov;
    bit          m_err;
    int          m_fc, m_ec;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s, input int l1, input int l2,
                                         input int r, input logic [31:0] c);
        logic [31:0] b;
        b = ((s << l1) ^ s) >> r;
        return ((s & c) << l2) ^ b;
    endfunction

    function automatic logic [31:0] seed(input logic [31:0] dflt, input logic [31:0] c,
                                         input logic [31:0] hdr);
        logic [31:0] s;
        s = dflt ^ hdr;
        if ((s & c) == 32'h0) s = dflt;
        return s;
    endfunction

    function automatic logic [SW-1:0] sat(input int v);
        return (v > (2**SW - 1)) ? SW'(2**SW - 1) : SW'(v);
    endfunction

    task automatic model_reset();
        m_s1 = 32'hFFFF_FFFF; m_s2 = 32'hCCCC_CCCC; m_s3 = 32'h00FF_00FF;
        m_payload = 1'b0; m_cnt = 0; m_ov = 1'b0; m_err = 1'b0;
        m_fc = 0; m_ec = 0;
        q.delete();
    endtask

    // One clock cycle: model the handshake from the inputs already applied,
    // advance the clock, then compare DUT outputs against the model.
    task automatic tick(output bit acc);
        exp_t        e;
        logic [31:0] k;
        bit          err_n;
        logic [SW-1:0] efc, eec;
        #1;
        acc   = 1'b0;
        err_n = 1'b0;
        if (rst) begin
            @(posedge clk);
            #1;
            model_reset();
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_data",  out_data,  0);
            check_eq("rst_out_last",  out_last,  0);
            check_eq("rst_frame_err", frame_err, 0);
            check_eq("rst_frame_cnt", frame_cnt, 0);
            check_eq("rst_err_cnt",   err_cnt,   0);
            return;
        end
        check_eq("in_ready", in_ready, !m_ov || out_ready);
        acc = in_valid && (!m_ov || out_ready);
        if (m_ov && out_ready) begin
            void'(q.pop_front());
            m_ov = 1'b0;
        end
        if (acc) begin
            if (in_sof) begin
                err_n     = m_payload;
                m_s1      = seed(32'hFFFF_FFFF, 32'hFFFF_FFFE, in_data);
                m_s2      = seed(32'hCCCC_CCCC, 32'hFFFF_FFF8, in_data);
                m_s3      = seed(32'h00FF_00FF, 32'hFFFF_FFF0, in_data);
                m_cnt     = 0;
                m_payload = 1'b1;
            end else if (!m_payload) begin
                err_n = 1'b1;
            end else begin
                m_s1 = step(m_s1, 13, 12, 19, 32'hFFFF_FFFE);
                m_s2 = step(m_s2, 2, 4, 25, 32'hFFFF_FFF8);
                m_s3 = step(m_s3, 3, 17, 11, 32'hFFFF_FFF0);
                k    = m_s1 ^ m_s2 ^ m_s3;
                e.d  = in_data ^ k;
                e.l  = (m_cnt == FL - 1);
                q.push_back(e);
                m_ov = 1'b1;
                m_cnt++;
                if (e.l) begin
                    m_payload = 1'b0;
                    m_fc++;
                end
            end
            if (err_n) m_ec++;
        end
        m_err = err_n;
        @(posedge clk);
        #1;
`ifdef TAUS_DESCR_STATS_EN
        efc = sat(m_fc);
        eec = sat(m_ec);
`else
        efc = '0;
        eec = '0;
`endif
        check_eq("out_valid", out_valid, m_ov);
        check_eq("frame_err", frame_err, m_err);
        check_eq("frame_cnt", frame_cnt, efc);
        check_eq("err_cnt",   err_cnt,   eec);
        if (m_ov) begin
            check_eq("out_data", out_data, q[0].d);
            check_eq("out_last", out_last, q[0].l);
        end
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send(input logic sof, input logic [31:0] d);
        bit acc;
        int tries;
        tries = 0;
        acc   = 1'b0;
        if (rnd_ready && ($urandom_range(0, 3) == 0)) begin
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            tick(acc);
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        do begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick(acc);
            tries++;
        end while (!acc && tries < 100);
        if (!acc) check_eq("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] w [FL]);
        send(1'b1, hdr);
        for (int i = 0; i < FL; i++) send(1'b0, w[i]);
    endtask

    logic [31:0] words [FL];
    logic [31:0] plain [FL];
    logic [31:0] g1, g2, g3;
    bit          acc_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        tick(acc_t);
        tick(acc_t);
        rst = 1'b0;

        // Golden keystream from default seeds
        foreach (words[i]) words[i] = 32'h0;
        send_frame(32'h0000_0000, words);
        idle(2);

        // c1 degenerate header
        foreach (words[i]) words[i] = $urandom;
        send_frame(32'hFFFF_FFFF, words);
        idle(1);

        // Loopback through an independent scrambler
        g1 = seed(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1234_5678);
        g2 = seed(32'hCCCC_CCCC, 32'hFFFF_FFF8, 32'h1234_5678);
        g3 = seed(32'h00FF_00FF, 32'hFFFF_FFF0, 32'h1234_5678);
        foreach (plain[i]) begin
            plain[i] = $urandom;
            g1 = step(g1, 13, 12, 19, 32'hFFFF_FFFE);
            g2 = step(g2, 2, 4, 25, 32'hFFFF_FFF8);
            g3 = step(g3, 3, 17, 11, 32'hFFFF_FFF0);
            words[i] = plain[i] ^ g1 ^ g2 ^ g3;
        end
        send(1'b1, 32'h1234_5678);
        for (int i = 0; i < FL; i++) begin
            send(1'b0, words[i]);
            check_eq("loopback_plain", out_data, plain[i]);
        end
        idle(1);

        // Payload word while in SYNC
        send(1'b0, 32'hDEAD_BEEF);
        idle(1);

        // Early header at payload word 5
        send(1'b1, 32'hA5A5_0001);
        for (int i = 0; i < 5; i++) send(1'b0, $urandom);
        foreach (words[i]) words[i] = $urandom;
        send_frame(32'h0BAD_CAFE, words);
        idle(1);

        // c2 and c3 degenerate headers
        send_frame(32'hCCCC_CCCC, words);
        send_frame(32'h00FF_00FF, words);
        idle(1);

        // Random output throttle with input bubbles
        rnd_ready = 1'b1;
        foreach (words[i]) words[i] = $urandom;
        send_frame(32'h5555_AAAA, words);

        // Reset mid-frame, with output possibly pending
        send(1'b1, 32'h7777_0000);
        for (int i = 0; i < 7; i++) send(1'b0, $urandom);
        rst = 1'b1;
        tick(acc_t);
        rst = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        send(1'b0, 32'h1111_2222);
        send_frame(32'h3333_4444, words);
        idle(1);

        // Error counter saturation
        for (int i = 0; i < 20; i++) send(1'b0, $urandom);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
